pic_uart: RTL and testbench
===========================

Name: pic_uart

Overview:
- PIC16-style asynchronous UART peripheral: TXSTA, RCSTA, SPBRG, TXREG and RCREG special-function registers.
- Interrupt-flag set strobes feed the PIR block.
- Sits on the core's SFR bus: one shared write-data bus, per-register write strobes and a receive-register read strobe.
- Asynchronous 8N1 frames, LSB first. Baud derived from clk via SPBRG/BRGH.

Parameters:
RCREG_DEPTH, 2, receive FIFO entries (RCREG plus hidden second stage).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- UART_TXD  out  1  serial transmit; idle high.
- UART_RXD  in  1  serial receive.
- reg_data_in  in  8  shared SFR write data.
- txsta_reg_wr_en  in  1  write TXSTA.
- txsta_reg_out  out  8  TXSTA readback.
- rcsta_reg_wr_en  in  1  write RCSTA.
- rcsta_reg_out  out  8  RCSTA readback.
- spbrg_reg_wr_en  in  1  write SPBRG.
- spbrg_reg_out  out  8  SPBRG readback.
- txreg_reg_wr_en  in  1  write TXREG; queues a byte for transmission.
- txreg_reg_out  out  8  TXREG readback.
- rcreg_reg_rd_en  in  1  pop receive FIFO head.
- rcreg_reg_out  out  8  receive FIFO head (0 when empty).
- txif_set_en  out  1  high whenever TXREG is empty.
- rxif_set_en  out  1  high whenever receive FIFO is non-empty.

Behaviour:
- Reset (async, rst=0): all registers 0 except TRMT=1. txsta_reg_out=0x02, txif_set_en=1, UART_TXD=1. TX FSM and RX FSM idle, FIFO empty, rxif_set_en=0.
- TXSTA bits: [7]CSRC, [6]TX9, [5]TXEN, [4]SYNC, [2]BRGH, [0]TX9D are writable. [1]TRMT is read-only (1 when TSR empty). [3] reads 0. CSRC/SYNC are stored only; the block is async-only.
- RCSTA bits: [7]SPEN, [6]RX9, [5]SREN, [4]CREN, [3]ADDEN, [0]RX9D are writable. [2]FERR and [1]OERR are read-only status. SREN/ADDEN are stored only.
- Register writes take effect on the clock edge and read back the next cycle. Readbacks are combinational from the registers.
- Baud generation:
  - Free-running 4-bit oversample counter; advances once per sample tick.
  - Sample tick every (SPBRG+1) clocks with BRGH=1, or every 4*(SPBRG+1) clocks with BRGH=0.
  - A bit tick occurs when the counter wraps 15->0.
  - Bit period is 16*(SPBRG+1) clocks (BRGH=1) or 64*(SPBRG+1) clocks (BRGH=0).
  - SPBRG=0, BRGH=1 gives a 16-clock bit period.
- TXREG handshake:
  - Write: TXREG captured; txif_set_en=0 the following cycle.
  - If TXEN=1 and TSR empty, TXREG transfers to TSR on the next edge (TSR loaded, TRMT=0). txif_set_en returns to 1 the cycle after that.
  - A TXREG write while TXREG is full overwrites it.
- TX FSM, states STOP (also idle), START, DATA, STOP:
  - In STOP with TSR loaded, the next bit tick is consumed one cycle later: -> START, UART_TXD=0.
  - START -> DATA after 16 sample ticks. DATA shifts 8 bits LSB first, one per bit period.
  - DATA -> STOP with UART_TXD=1 for one bit period. At the end, TRMT=1 unless TXREG reloads the TSR, which starts the next START back-to-back.
  - TXEN=0 or SPEN=0 aborts the frame: UART_TXD=1, FSM to STOP, TSR emptied.
- RX FSM, states STOP (idle), START, DATA, STOP; enabled only when SPEN=1 and CREN=1:
  - Idle: registered falling edge on UART_RXD -> START one cycle after the line goes low. The oversample phase is realigned to the edge.
  - Each bit is sampled at sample count 8.
  - START: if the line samples high, return to idle (false start).
  - DATA: 8 bits into RSR, LSB first.
  - STOP: at the stop sample point, one-cycle internal rcreg write strobe. FERR is set to the inverse of the sampled stop bit. Then idle.
- Receive FIFO:
  - Write pushes RSR. rxif_set_en reflects "FIFO non-empty", registered, so it rises the cycle after the write.
  - Write while full: byte dropped, OERR=1. OERR is cleared only by writing CREN=0.
  - rcreg_reg_rd_en pops on the clock edge. rcreg_reg_out and rxif_set_en change the cycle after the edge.
  - Empty head reads 0. Simultaneous push and pop is allowed: the pop happens first, then the push.
- UART_TXD and UART_RXD may be looped externally; loopback must work.

Optional Feature:
UART_NINE_BIT_EN:
- Defined: TX9=1 sends TX9D as a 9th data bit before STOP. RX9=1 receives a 9th bit into RX9D, stored per FIFO entry with the byte.
- Undefined: TX9, TX9D, RX9 and RX9D read 0 and writes are ignored; frames are always 8 data bits.

Test Plan:
- Reset release -> txsta_reg_out=0x02, txif_set_en=1, spbrg_reg_out=0, txreg_reg_out=0, UART_TXD=1.
- Write RCSTA=0x90 -> reads 0x90. Write TXSTA=0x24 -> reads 0x26.
- Write TXREG=0xCA -> next cycle txif_set_en=0 and TSR loads; the cycle after, txif_set_en=1 and TRMT=0.
- Transmit 0xCA with SPBRG=0, BRGH=1:
  - UART_TXD: start 0, then 0,1,0,1,0,0,1,1, then stop 1, each 16 clocks.
  - After the stop bit, TRMT=1.
- Loopback TXD->RXD:
  - RX reaches START one cycle after TXD falls.
  - Internal rcreg write strobe fires during STOP; next cycle rcreg_reg_out=0xCA and rxif_set_en=1.
  - Pulse rcreg_reg_rd_en for one cycle -> the cycle after the edge, rxif_set_en=0 and rcreg_reg_out=0.
- Three frames received without reads -> first two bytes retained in order, OERR=1. Writing CREN=0 clears OERR.

Source files
------------

// File: rtl/pic_uart.sv
// -----------------------------------------------------------------------------
// pic_uart
//   PIC16-style asynchronous UART. It provides the TXSTA, RCSTA, SPBRG, TXREG
//   and RCREG special-function registers. Frames are 8N1, LSB first. The baud
//   rate comes from clk through SPBRG and BRGH. The receive FIFO is RCREG plus
//   hidden stages.
//
//   Optional feature macro: UART_NINE_BIT_EN
//     When defined, TX9/TX9D add a 9th transmitted bit, and RX9 receives a 9th
//     bit that is stored with each FIFO entry and read back as RCSTA.RX9D.
//     When undefined, TX9, TX9D, RX9 and RX9D read 0 and frames carry 8 bits.
//
//   Ports
//     clk               system clock
//     rst               asynchronous active-low reset
//     UART_TXD          serial transmit (idle high)
//     UART_RXD          serial receive
//     reg_data_in       shared SFR write data
//     txsta_reg_wr_en   write TXSTA      / txsta_reg_out  TXSTA readback
//     rcsta_reg_wr_en   write RCSTA      / rcsta_reg_out  RCSTA readback
//     spbrg_reg_wr_en   write SPBRG      / spbrg_reg_out  SPBRG readback
//     txreg_reg_wr_en   write TXREG      / txreg_reg_out  TXREG readback
//     rcreg_reg_rd_en   pop FIFO head    / rcreg_reg_out  FIFO head (0 if empty)
//     txif_set_en       TXREG empty
//     rxif_set_en       receive FIFO non-empty
// -----------------------------------------------------------------------------
module pic_uart #(
   parameter int RCREG_DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst,
   output logic       UART_TXD,
   input  logic       UART_RXD,
   input  logic [7:0] reg_data_in,
   input  logic       txsta_reg_wr_en,
   output logic [7:0] txsta_reg_out,
   input  logic       rcsta_reg_wr_en,
   output logic [7:0] rcsta_reg_out,
   input  logic       spbrg_reg_wr_en,
   output logic [7:0] spbrg_reg_out,
   input  logic       txreg_reg_wr_en,
   output logic [7:0] txreg_reg_out,
   input  logic       rcreg_reg_rd_en,
   output logic [7:0] rcreg_reg_out,
   output logic       txif_set_en,
   output logic       rxif_set_en
);

`ifdef UART_NINE_BIT_EN
   localparam int         FW          = 9;
   localparam logic [7:0] TXSTA_WMASK = 8'hF5;
   localparam logic [7:3] RCSTA_WMASK = 5'b11111;
`else
   localparam int         FW          = 8;
   localparam logic [7:0] TXSTA_WMASK = 8'hB4;
   localparam logic [7:3] RCSTA_WMASK = 5'b10111;
`endif
   localparam int PW = (RCREG_DEPTH > 1) ? $clog2(RCREG_DEPTH) : 1;
   localparam int CW = $clog2(RCREG_DEPTH + 1);

   // IDLE is the line-high rest state. STOP is the stop bit being sent or checked.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_st_e;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(RCREG_DEPTH - 1)) return {PW{1'b0}};
      else                           return p + PW'(1);
   endfunction

   // Register storage
   logic [7:0]    txsta_q;
   logic [7:3]    rcsta_q;
   logic [7:0]    spbrg_q;
   logic [7:0]    txreg_q;
   logic          txreg_full_q;
   logic [FW-1:0] tsr_q;
   logic          tsr_full_q;
   uart_st_e      tx_state_q;
   logic [3:0]    tx_bit_cnt_q;
   logic          txd_q;
   logic [9:0]    presc_q;
   logic [3:0]    os_q;
   logic          bit_tick_q;
   logic          rxd_q;
   uart_st_e      rx_state_q;
   logic [9:0]    rx_presc_q;
   logic [3:0]    rx_os_q;
   logic [3:0]    rx_bit_cnt_q;
   logic [FW-1:0] rsr_q;
   logic          ferr_q;
   logic          oerr_q;
   logic [FW-1:0] fifo_q [RCREG_DEPTH];
   logic [PW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CW-1:0] count_q, count_d, cnt_mid_s;

   logic [9:0]    baud_limit_s;
   logic          sample_tick_s, rx_tick_s, rx_sample_s, rx_fall_s;
   logic          tx_en_s, rx_en_s, tx_load_s, rx_push_s;
   logic          pop_s, push_ok_s, ovf_s;
   logic [3:0]    tx_last_s, rx_last_s;
   logic [FW-1:0] tx_frame_s, rx_entry_s, head_s;
   logic          rx9d_s;

   assign tx_en_s = txsta_q[5] & rcsta_q[7];
   assign rx_en_s = rcsta_q[7] & rcsta_q[4];

   // BRGH=1: tick every SPBRG+1 clocks. BRGH=0: tick every 4*(SPBRG+1) clocks.
   assign baud_limit_s  = txsta_q[2] ? {2'b00, spbrg_q} : {spbrg_q, 2'b11};
   // Use >= so the tick period settles at once after a BRGH/SPBRG change.
   assign sample_tick_s = (presc_q >= baud_limit_s);
   assign rx_tick_s     = (rx_presc_q >= baud_limit_s);
   assign rx_sample_s   = rx_tick_s && (rx_os_q == 4'd8);
   // Compare the registered line with the live input so that START is reached
   // one cycle after the line goes low.
   assign rx_fall_s     = rxd_q & ~UART_RXD;

`ifdef UART_NINE_BIT_EN
   assign tx_frame_s = {txsta_q[0], txreg_q};
   assign tx_last_s  = txsta_q[6] ? 4'd8 : 4'd7;
   assign rx_last_s  = rcsta_q[6] ? 4'd8 : 4'd7;
   // An 8-bit frame shifted into the 9-bit RSR sits one position high.
   assign rx_entry_s = rcsta_q[6] ? rsr_q : {1'b0, rsr_q[8:1]};
   assign rx9d_s     = (count_q != {CW{1'b0}}) ? head_s[8] : 1'b0;
`else
   assign tx_frame_s = txreg_q;
   assign tx_last_s  = 4'd7;
   assign rx_last_s  = 4'd7;
   assign rx_entry_s = rsr_q;
   assign rx9d_s     = 1'b0;
`endif

   // TSR takes TXREG when the TSR is idle and empty, or right at the end of a
   // stop bit. The second case gives back-to-back frames.
   assign tx_load_s = tx_en_s && txreg_full_q &&
                      (((tx_state_q == ST_IDLE) && !tsr_full_q) ||
                       ((tx_state_q == ST_STOP) && bit_tick_q));

   assign rx_push_s = rx_en_s && (rx_state_q == ST_STOP) && rx_sample_s;
   assign pop_s     = rcreg_reg_rd_en && (count_q != {CW{1'b0}});
   assign head_s    = fifo_q[rd_ptr_q];

   // FIFO occupancy: the pop is taken first, then the push is tried.
   always_comb begin
      cnt_mid_s = count_q - CW'(pop_s);
      if (rx_push_s && (cnt_mid_s != CW'(RCREG_DEPTH))) begin
         push_ok_s = 1'b1;
         ovf_s     = 1'b0;
      end else begin
         push_ok_s = 1'b0;
         ovf_s     = rx_push_s;
      end
      count_d = cnt_mid_s + CW'(push_ok_s);
   end

   // Control registers written from the SFR bus.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         txsta_q <= 8'h00;
         rcsta_q <= 5'b00000;
         spbrg_q <= 8'h00;
      end else begin
         if (txsta_reg_wr_en) txsta_q <= reg_data_in & TXSTA_WMASK;
         if (rcsta_reg_wr_en) rcsta_q <= reg_data_in[7:3] & RCSTA_WMASK;
         if (spbrg_reg_wr_en) spbrg_q <= reg_data_in;
      end
   end

   // Shared baud prescaler and free-running oversample counter for transmit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc_q    <= 10'd0;
         os_q       <= 4'd0;
         bit_tick_q <= 1'b0;
      end else begin
         presc_q    <= sample_tick_s ? 10'd0 : presc_q + 10'd1;
         if (sample_tick_s) os_q <= os_q + 4'd1;
         bit_tick_q <= sample_tick_s && (os_q == 4'hF);
      end
   end

   // TXREG holding register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         txreg_q      <= 8'h00;
         txreg_full_q <= 1'b0;
      end else begin
         if (txreg_reg_wr_en) begin
            txreg_q      <= reg_data_in;
            txreg_full_q <= 1'b1;
         end else if (tx_load_s) begin
            txreg_full_q <= 1'b0;
         end
      end
   end

   // Transmit shift register and transmit FSM. UART_TXD is registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tsr_q        <= {FW{1'b0}};
         tsr_full_q   <= 1'b0;
         tx_state_q   <= ST_IDLE;
         tx_bit_cnt_q <= 4'd0;
         txd_q        <= 1'b1;
      end else if (!tx_en_s) begin
         tsr_full_q <= 1'b0;
         tx_state_q <= ST_IDLE;
         txd_q      <= 1'b1;
      end else begin
         case (tx_state_q)
            ST_IDLE: begin
               if (tx_load_s) begin
                  tsr_q      <= tx_frame_s;
                  tsr_full_q <= 1'b1;
               end else if (tsr_full_q && bit_tick_q) begin
                  tx_state_q <= ST_START;
                  txd_q      <= 1'b0;
               end
            end
            ST_START: begin
               if (bit_tick_q) begin
                  tx_state_q   <= ST_DATA;
                  txd_q        <= tsr_q[0];
                  tsr_q        <= tsr_q >> 1;
                  tx_bit_cnt_q <= 4'd0;
               end
            end
            ST_DATA: begin
               if (bit_tick_q) begin
                  if (tx_bit_cnt_q == tx_last_s) begin
                     tx_state_q <= ST_STOP;
                     txd_q      <= 1'b1;
                  end else begin
                     txd_q        <= tsr_q[0];
                     tsr_q        <= tsr_q >> 1;
                     tx_bit_cnt_q <= tx_bit_cnt_q + 4'd1;
                  end
               end
            end
            ST_STOP: begin
               if (bit_tick_q) begin
                  if (tx_load_s) begin
                     tsr_q      <= tx_frame_s;
                     tx_state_q <= ST_START;
                     txd_q      <= 1'b0;
                  end else begin
                     tsr_full_q <= 1'b0;
                     tx_state_q <= ST_IDLE;
                  end
               end
            end
            default: begin
               tx_state_q <= ST_IDLE;
               txd_q      <= 1'b1;
            end
         endcase
      end
   end

   // Receive line register, edge-aligned oversampling and receive FSM.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rxd_q        <= 1'b1;
         rx_state_q   <= ST_IDLE;
         rx_presc_q   <= 10'd0;
         rx_os_q      <= 4'd0;
         rx_bit_cnt_q <= 4'd0;
         rsr_q        <= {FW{1'b0}};
         ferr_q       <= 1'b0;
      end else begin
         rxd_q <= UART_RXD;
         if (rx_tick_s) begin
            rx_presc_q <= 10'd0;
            rx_os_q    <= rx_os_q + 4'd1;
         end else begin
            rx_presc_q <= rx_presc_q + 10'd1;
         end
         if (!rx_en_s) begin
            rx_state_q <= ST_IDLE;
         end else begin
            case (rx_state_q)
               ST_IDLE: begin
                  if (rx_fall_s) begin
                     rx_state_q <= ST_START;
                     rx_presc_q <= 10'd0;
                     rx_os_q    <= 4'd0;
                  end
               end
               ST_START: begin
                  if (rx_sample_s) begin
                     if (rxd_q) begin
                        rx_state_q <= ST_IDLE;
                     end else begin
                        rx_state_q   <= ST_DATA;
                        rx_bit_cnt_q <= 4'd0;
                        rsr_q        <= {FW{1'b0}};
                     end
                  end
               end
               ST_DATA: begin
                  if (rx_sample_s) begin
                     rsr_q <= {rxd_q, rsr_q[FW-1:1]};
                     if (rx_bit_cnt_q == rx_last_s) rx_state_q <= ST_STOP;
                     else rx_bit_cnt_q <= rx_bit_cnt_q + 4'd1;
                  end
               end
               ST_STOP: begin
                  if (rx_sample_s) begin
                     ferr_q     <= ~rxd_q;
                     rx_state_q <= ST_IDLE;
                  end
               end
               default: rx_state_q <= ST_IDLE;
            endcase
         end
      end
   end

   // Receive FIFO pointers, occupancy and overrun flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q <= {PW{1'b0}};
         wr_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
         oerr_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         if (pop_s)     rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (push_ok_s) wr_ptr_q <= ptr_inc(wr_ptr_q);
         // Writing CREN=0 is the only way to clear the overrun flag.
         if (rcsta_reg_wr_en && !reg_data_in[4]) oerr_q <= 1'b0;
         else if (ovf_s)                         oerr_q <= 1'b1;
      end
   end

   // Receive FIFO storage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < RCREG_DEPTH; i++) fifo_q[i] <= {FW{1'b0}};
      end else begin
         if (push_ok_s) fifo_q[wr_ptr_q] <= rx_entry_s;
      end
   end

   assign UART_TXD      = txd_q;
   assign txsta_reg_out = txsta_q | {6'b000000, ~tsr_full_q, 1'b0};
   assign rcsta_reg_out = {rcsta_q, ferr_q, oerr_q, rx9d_s};
   assign spbrg_reg_out = spbrg_q;
   assign txreg_reg_out = txreg_q;
   assign rcreg_reg_out = (count_q != {CW{1'b0}}) ? head_s[7:0] : 8'h00;
   assign txif_set_en   = ~txreg_full_q;
   assign rxif_set_en   = (count_q != {CW{1'b0}});

endmodule

// File: tb/tb_pic_uart.sv
module tb_pic_uart;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       txd, rxd;
   logic [7:0] reg_data_in = 8'h00;
   logic       txsta_wr = 1'b0, rcsta_wr = 1'b0, spbrg_wr = 1'b0;
   logic       txreg_wr = 1'b0, rcreg_rd = 1'b0;
   logic [7:0] txsta_o, rcsta_o, spbrg_o, txreg_o, rcreg_o;
   logic       txif, rxif;
   int         n_total = 0;
   int         n_bad   = 0;

   assign rxd = txd;   // external loopback
   always #5 clk = ~clk;

   pic_uart #(.RCREG_DEPTH(2)) dut (
      .clk             (clk),
      .rst             (rst),
      .UART_TXD        (txd),
      .UART_RXD        (rxd),
      .reg_data_in     (reg_data_in),
      .txsta_reg_wr_en (txsta_wr),
      .txsta_reg_out   (txsta_o),
      .rcsta_reg_wr_en (rcsta_wr),
      .rcsta_reg_out   (rcsta_o),
      .spbrg_reg_wr_en (spbrg_wr),
      .spbrg_reg_out   (spbrg_o),
      .txreg_reg_wr_en (txreg_wr),
      .txreg_reg_out   (txreg_o),
      .rcreg_reg_rd_en (rcreg_rd),
      .rcreg_reg_out   (rcreg_o),
      .txif_set_en     (txif),
      .rxif_set_en     (rxif)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // sel: 0 TXSTA, 1 RCSTA, 2 SPBRG, 3 TXREG. Returns on the negedge after the write edge.
   task automatic sfr_wr(input int sel, input logic [7:0] d);
      @(negedge clk);
      reg_data_in = d;
      case (sel)
         0: txsta_wr = 1'b1;
         1: rcsta_wr = 1'b1;
         2: spbrg_wr = 1'b1;
         3: txreg_wr = 1'b1;
         default: ;
      endcase
      @(negedge clk);
      txsta_wr = 1'b0; rcsta_wr = 1'b0; spbrg_wr = 1'b0; txreg_wr = 1'b0;
   endtask

   task automatic pop();
      @(negedge clk);
      rcreg_rd = 1'b1;
      @(negedge clk);
      rcreg_rd = 1'b0;
   endtask

   task automatic wait_txd_low(input string tag, input int max);
      int n = 0;
      while (txd !== 1'b0 && n < max) begin @(negedge clk); n++; end
      check(tag, {15'd0, txd}, 16'd0);
   endtask

   task automatic wait_txif(input string tag, input int max);
      int n = 0;
      while (txif !== 1'b1 && n < max) begin @(negedge clk); n++; end
      check(tag, {15'd0, txif}, 16'd1);
   endtask

   task automatic wait_trmt(input string tag, input int max);
      int n = 0;
      while (txsta_o[1] !== 1'b1 && n < max) begin @(negedge clk); n++; end
      check(tag, {15'd0, txsta_o[1]}, 16'd1);
   endtask

   // Length of the start bit, in clocks, for a byte whose bit 0 is 1.
   task automatic measure_start(input string tag, input int exp_len);
      int n = 0;
      wait_txd_low({tag, "_fall"}, 400);
      while (txd === 1'b0 && n < 1000) begin @(negedge clk); n++; end
      check(tag, n[15:0], exp_len[15:0]);
   endtask

   initial begin
      logic [7:0] byte_v;
      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_txsta", {8'h00, txsta_o}, 16'h0002);
      check("rst_rcsta", {8'h00, rcsta_o}, 16'h0000);
      check("rst_spbrg", {8'h00, spbrg_o}, 16'h0000);
      check("rst_txreg", {8'h00, txreg_o}, 16'h0000);
      check("rst_txif",  {15'd0, txif}, 16'd1);
      check("rst_rxif",  {15'd0, rxif}, 16'd0);
      check("rst_txd",   {15'd0, txd},  16'd1);
      rst = 1'b1;

      // Register writes and masked readbacks.
      sfr_wr(1, 8'h90);
      check("rcsta_rd", {8'h00, rcsta_o}, 16'h0090);
      sfr_wr(0, 8'h24);
      check("txsta_rd", {8'h00, txsta_o}, 16'h0026);
      sfr_wr(2, 8'h5A);
      check("spbrg_rd", {8'h00, spbrg_o}, 16'h005A);
      sfr_wr(2, 8'h00);

      // TXREG handshake.
      sfr_wr(3, 8'hCA);
      check("txreg_rd",    {8'h00, txreg_o}, 16'h00CA);
      check("txif_low",    {15'd0, txif}, 16'd0);
      check("trmt_before", {15'd0, txsta_o[1]}, 16'd1);
      @(negedge clk);
      check("txif_back",   {15'd0, txif}, 16'd1);
      check("trmt_load",   {15'd0, txsta_o[1]}, 16'd0);

      // Serial frame for 0xCA, 16 clocks per bit, sampled at mid-bit.
      wait_txd_low("ca_fall", 100);
      repeat (8) @(negedge clk);
      check("ca_start", {15'd0, txd}, 16'd0);
      byte_v = 8'hCA;
      for (int i = 0; i < 8; i++) begin
         repeat (16) @(negedge clk);
         check($sformatf("ca_bit%0d", i), {15'd0, txd}, {15'd0, byte_v[i]});
      end
      repeat (16) @(negedge clk);
      check("ca_stop",      {15'd0, txd}, 16'd1);
      check("ca_trmt_busy", {15'd0, txsta_o[1]}, 16'd0);
      repeat (12) @(negedge clk);
      check("ca_trmt_done", {15'd0, txsta_o[1]}, 16'd1);
      check("lb_rxif",      {15'd0, rxif}, 16'd1);
      check("lb_rcreg",     {8'h00, rcreg_o}, 16'h00CA);
      check("lb_rcsta",     {8'h00, rcsta_o}, 16'h0090);
      pop();
      check("pop_rxif",  {15'd0, rxif}, 16'd0);
      check("pop_rcreg", {8'h00, rcreg_o}, 16'h0000);

      // Three back-to-back frames without reads: overrun.
      sfr_wr(3, 8'hA5);
      wait_txif("ovf_txif1", 50);
      sfr_wr(3, 8'h3C);
      wait_txif("ovf_txif2", 400);
      sfr_wr(3, 8'h81);
      wait_txif("ovf_txif3", 400);
      wait_trmt("ovf_trmt", 1000);
      repeat (4) @(negedge clk);
      check("ovf_rcsta", {8'h00, rcsta_o}, 16'h0092);
      check("ovf_head0", {8'h00, rcreg_o}, 16'h00A5);
      pop();
      check("ovf_head1", {8'h00, rcreg_o}, 16'h003C);
      check("ovf_rxif1", {15'd0, rxif}, 16'd1);
      pop();
      check("ovf_empty", {15'd0, rxif}, 16'd0);
      sfr_wr(1, 8'h80);
      check("oerr_clr", {8'h00, rcsta_o}, 16'h0080);
      sfr_wr(1, 8'h90);

      // BRGH=0, SPBRG=0: 64-clock bit period.
      sfr_wr(0, 8'h20);
      check("brgh0_txsta", {8'h00, txsta_o}, 16'h0022);
      sfr_wr(3, 8'h01);
      measure_start("brgh0_period", 64);
      wait_trmt("brgh0_trmt", 2000);
      repeat (4) @(negedge clk);
      check("brgh0_rx", {8'h00, rcreg_o}, 16'h0001);
      pop();

      // BRGH=1, SPBRG=2: 48-clock bit period.
      sfr_wr(2, 8'h02);
      sfr_wr(0, 8'h24);
      sfr_wr(3, 8'h01);
      measure_start("spbrg2_period", 48);
      wait_trmt("spbrg2_trmt", 2000);
      repeat (4) @(negedge clk);
      check("spbrg2_rx", {8'h00, rcreg_o}, 16'h0001);
      pop();
      sfr_wr(2, 8'h00);

      // TXEN=0 during a frame aborts it.
      sfr_wr(3, 8'h5A);
      wait_txd_low("abort_fall", 100);
      repeat (20) @(negedge clk);
      sfr_wr(0, 8'h04);
      @(negedge clk);
      check("abort_txd",   {15'd0, txd}, 16'd1);
      check("abort_txsta", {8'h00, txsta_o}, 16'h0006);

      // With TXEN=0, a second TXREG write overwrites the first.
      sfr_wr(3, 8'h11);
      sfr_wr(3, 8'h22);
      @(negedge clk);
      check("ovr_txreg", {8'h00, txreg_o}, 16'h0022);
      check("ovr_txif",  {15'd0, txif}, 16'd0);
      check("ovr_trmt",  {15'd0, txsta_o[1]}, 16'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
